// File: rtl/pipe_adder_pkg.sv
// Shared constants for the segmented adder/subtractor family.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_seg.sv
// One SEG-bit slice of the segmented adder: sum, carry-out and carry into the slice MSB.
module adder_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  // The carry into the MSB is recovered from the MSB sum bit, so it works for any SEG >= 1.
  assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit carry-chained segment per stage,
// valid/ready handshake with a single global advance enable.
module pipe_seg_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / SEG;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             valid_chain [STAGES];
  logic             carry_chain [STAGES];
  logic             ovf_chain   [STAGES];
  logic [WIDTH-1:0] opa_chain   [STAGES];
  logic [WIDTH-1:0] opb_chain   [STAGES];

  assign en       = !valid_chain[STAGES-1] || out_ready;
  assign in_ready = en;

  assign b_eff   = (in_op == OP_SUB) ? ~in_b : in_b;
  assign cin_eff = (in_op == OP_SUB) ? 1'b1  : in_cin;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic             c_src;
      logic             v_src;
      logic [WIDTH-1:0] a_next;
      logic [WIDTH-1:0] b_next;
      logic [SEG-1:0]   seg_sum;
      logic             seg_cout;
      logic             seg_cmsb;

      logic             valid_reg;
      logic             carry_reg;
      logic             ovf_reg;
      logic [WIDTH-1:0] opa_reg;
      logic [WIDTH-1:0] opb_reg;

      if (gi == 0) begin : g_first
        assign a_src = in_a;
        assign b_src = b_eff;
        assign c_src = cin_eff;
        assign v_src = in_valid;
      end else begin : g_chain
        assign a_src = opa_chain[gi-1];
        assign b_src = opb_chain[gi-1];
        assign c_src = carry_chain[gi-1];
        assign v_src = valid_chain[gi-1];
      end

      adder_seg #(.SEG(SEG)) u_seg (
        .a     (a_src[SEG-1:0]),
        .b     (b_src[SEG-1:0]),
        .cin   (c_src),
        .sum   (seg_sum),
        .cout  (seg_cout),
        .c_msb (seg_cmsb)
      );

      // Operands rotate right by one segment per stage; each finished segment sum
      // enters at the top, so after the last stage the word is already in order.
      if (STAGES == 1) begin : g_single
        assign a_next = seg_sum;
        assign b_next = b_src;
      end else begin : g_rot
        assign a_next = {seg_sum, a_src[WIDTH-1:SEG]};
        assign b_next = {b_src[SEG-1:0], b_src[WIDTH-1:SEG]};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          ovf_reg   <= 1'b0;
          opa_reg   <= '0;
          opb_reg   <= '0;
        end else if (en) begin
          valid_reg <= v_src;
          carry_reg <= seg_cout;
          ovf_reg   <= seg_cout ^ seg_cmsb;
          opa_reg   <= a_next;
          opb_reg   <= b_next;
        end
      end

      assign valid_chain[gi] = valid_reg;
      assign carry_chain[gi] = carry_reg;
      assign ovf_chain[gi]   = ovf_reg;
      assign opa_chain[gi]   = opa_reg;
      assign opb_chain[gi]   = opb_reg;
    end
  endgenerate

  assign out_valid = valid_chain[STAGES-1];
  assign out_sum   = opa_chain[STAGES-1];
  assign out_cout  = carry_chain[STAGES-1];
  assign out_ovf   = ovf_chain[STAGES-1];

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Self-checking bench: directed vectors on a 32/8 instance, randomized traffic on an 8/4 instance.
module tb_pipe_seg_adder;
  import pipe_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic        in_valid = 1'b0, in_cin = 1'b0, in_op = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_cout, out_ovf;
  logic [31:0] in_a = '0, in_b = '0, out_sum;

  logic        w8_in_valid = 1'b0, w8_in_cin = 1'b0, w8_in_op = 1'b0, w8_out_ready = 1'b1;
  logic        w8_in_ready, w8_out_valid, w8_out_cout, w8_out_ovf;
  logic [7:0]  w8_in_a = '0, w8_in_b = '0, w8_out_sum;

  pipe_seg_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipe_seg_adder #(.WIDTH(8), .SEG(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .in_a(w8_in_a), .in_b(w8_in_b), .in_cin(w8_in_cin), .in_op(w8_in_op),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_sum(w8_out_sum),
    .out_cout(w8_out_cout), .out_ovf(w8_out_ovf)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  // Reference: plain integer arithmetic; overflow from the true signed result range.
  function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic op);
    longint mask, ua, ub, full, half, sa, sb, sr;
    res_t r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    if (op == OP_SUB) full = ua + ((~ub) & mask) + 1;
    else              full = ua + ub + longint'(cin);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    sr = (op == OP_SUB) ? sa - sb : sa + sb + longint'(cin);
    r.sum  = 32'(full & mask);
    r.cout = ((full >> w) & 1) != 0;
    r.ovf  = (sr >= half) || (sr < -half);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1;
    w8_in_valid = 1'b1; w8_in_a = 8'h3; w8_in_b = 8'h4;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; w8_in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b want 0/0/0/0", out_valid, out_sum, out_cout, out_ovf);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || w8_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, w8_in_ready);
    end
    n_cmp++;
    if (w8_out_valid !== 1'b0 || w8_out_sum !== 8'h0) begin
      n_err++;
      $display("FAIL reset_w8: got valid=%b sum=%h want 0/00", w8_out_valid, w8_out_sum);
    end
    repeat (6) @(posedge clk);
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || w8_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_beat_dropped: got out_valid=%b/%b want 0/0", out_valid, w8_out_valid);
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_directed();
    logic [31:0] va [4], vb [4], es [4];
    logic        vc [4], vo [4], ec [4], eo [4];
    int          t0;
    bit          found;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'h1; vc[0] = 1'b0; vo[0] = OP_ADD; es[0] = 32'h0;        ec[0] = 1'b1; eo[0] = 1'b0;
    va[1] = 32'h5;        vb[1] = 32'h7; vc[1] = 1'b1; vo[1] = OP_SUB; es[1] = 32'hFFFFFFFE; ec[1] = 1'b0; eo[1] = 1'b0;
    va[2] = 32'h80000000; vb[2] = 32'h1; vc[2] = 1'b0; vo[2] = OP_SUB; es[2] = 32'h7FFFFFFF; ec[2] = 1'b1; eo[2] = 1'b1;
    va[3] = 32'h7FFFFFFF; vb[3] = 32'h0; vc[3] = 1'b1; vo[3] = OP_ADD; es[3] = 32'h80000000; ec[3] = 1'b0; eo[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_cin = vc[i]; in_op = vo[i]; out_ready = 1'b1;
      #1;
      t0 = cyc;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
        if (out_valid === 1'b1) found = 1'b1;
        else begin @(posedge clk); #2; end
      end
      n_cmp++;
      if (!found) begin
        n_err++;
        $display("FAIL dir%0d_timeout: got no out_valid want result", i);
      end else begin
        if (cyc - t0 != 4) begin
          n_err++;
          $display("FAIL dir%0d_latency: got %0d want 4", i, cyc - t0);
        end
        n_cmp++;
        if (out_sum !== es[i] || out_cout !== ec[i] || out_ovf !== eo[i]) begin
          n_err++;
          $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   i, out_sum, out_cout, out_ovf, es[i], ec[i], eo[i]);
        end
      end
      $display("directed %0d: a=%h b=%h cin=%b op=%b -> sum=%h cout=%b ovf=%b",
               i, va[i], vb[i], vc[i], vo[i], out_sum, out_cout, out_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int t0, rel;
    @(posedge clk); #1;
    t0 = cyc;
    for (int s = 0; s < 9; s++) begin
      in_valid = (s < 3);
      in_a = 32'(s + 1); in_b = 32'(s + 1); in_cin = 1'b0; in_op = OP_ADD; out_ready = 1'b1;
      #1;
      rel = cyc - t0;
      if (rel >= 4 && rel <= 6) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 32'(2 * (rel - 3))) begin
          n_err++;
          $display("FAIL b2b_rel%0d: got valid=%b sum=%h want 1/%h", rel, out_valid, out_sum, 32'(2 * (rel - 3)));
        end else $display("back_to_back rel %0d: sum=%h", rel, out_sum);
      end
      if (rel == 3 || rel == 7) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_gap_rel%0d: got valid=%b want 0", rel, out_valid);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    res_t q[$];
    res_t e;
    int t0, rel, sent, got;
    sent = 0; got = 0;
    @(posedge clk); #1;
    t0 = cyc;
    for (int s = 0; s < 20; s++) begin
      rel = cyc - t0;
      out_ready = !(rel >= 4 && rel <= 6);
      in_valid = (sent < 5);
      in_a = $urandom(); in_b = $urandom();
      in_cin = 1'($urandom_range(0, 1)); in_op = 1'($urandom_range(0, 1));
      #1;
      if (rel >= 4 && rel <= 6) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stall_in_ready_rel%0d: got %b want 0", rel, in_ready);
        end
        n_cmp++;
        if (q.size() == 0 || out_valid !== 1'b1 || out_sum !== q[0].sum) begin
          n_err++;
          $display("FAIL stall_hold_rel%0d: got valid=%b sum=%h want held head result", rel, out_valid, out_sum);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL stall_extra: got sum=%h want no result", out_sum);
        end else begin
          e = q.pop_front();
          got++;
          if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
            n_err++;
            $display("FAIL stall_result%0d: got %h/%b/%b want %h/%b/%b", got, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
          end else $display("stall result %0d: sum=%h cout=%b ovf=%b", got, out_sum, out_cout, out_ovf);
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(32, in_a, in_b, in_cin, in_op));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got != 5 || q.size() != 0) begin
      n_err++;
      $display("FAIL stall_count: got %0d delivered (%0d pending) want 5 (0)", got, q.size());
    end
  endtask

  task automatic test_reset_flight();
    int  t0, seen;
    bit  found;
    @(posedge clk); #1;
    out_ready = 1'b1; in_op = OP_ADD; in_cin = 1'b0;
    in_valid = 1'b1; in_a = 32'h10; in_b = 32'h20;
    @(posedge clk); #1;
    in_a = 32'h30; in_b = 32'h40;
    @(posedge clk); #1;
    rst = 1'b1; in_a = 32'h50; in_b = 32'h60;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstflight_clear: got valid=%b sum=%h in_ready=%b want 0/0/1", out_valid, out_sum, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #2;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rstflight_ghost: got %0d results want 0", seen);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h11111111;
    #1;
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (out_valid === 1'b1) found = 1'b1;
      else begin @(posedge clk); #2; end
    end
    n_cmp++;
    if (!found || cyc - t0 != 4 || out_sum !== 32'h23456789 || out_cout !== 1'b0) begin
      n_err++;
      $display("FAIL rstflight_after: got found=%b lat=%0d sum=%h want 1/4/23456789", found, cyc - t0, out_sum);
    end else $display("reset_flight post-reset beat: sum=%h", out_sum);
  endtask

  task automatic test_random8();
    res_t q[$];
    res_t e;
    int   got, errs_before;
    logic prev_stall;
    logic [7:0] prev_sum;
    got = 0; errs_before = n_err; prev_stall = 1'b0; prev_sum = '0;
    @(posedge clk); #1;
    for (int s = 0; s < 3000 + 30; s++) begin
      if (s < 3000) begin
        w8_in_valid  = ($urandom_range(0, 9) < 8);
        w8_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        w8_in_valid  = 1'b0;
        w8_out_ready = 1'b1;
      end
      w8_in_a = 8'($urandom()); w8_in_b = 8'($urandom());
      w8_in_cin = 1'($urandom_range(0, 1)); w8_in_op = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (w8_in_ready !== (!w8_out_valid || w8_out_ready)) begin
        n_err++;
        $display("FAIL rnd_in_ready: got %b want %b", w8_in_ready, !w8_out_valid || w8_out_ready);
      end
      if (prev_stall) begin
        n_cmp++;
        if (w8_out_valid !== 1'b1 || w8_out_sum !== prev_sum) begin
          n_err++;
          $display("FAIL rnd_stall_hold: got valid=%b sum=%h want 1/%h", w8_out_valid, w8_out_sum, prev_sum);
        end
      end
      if (w8_out_valid === 1'b1 && w8_out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_extra: got sum=%h want no result", w8_out_sum);
        end else begin
          e = q.pop_front();
          got++;
          if ({24'h0, w8_out_sum} !== e.sum || w8_out_cout !== e.cout || w8_out_ovf !== e.ovf) begin
            n_err++;
            $display("FAIL rnd_result%0d: got %h/%b/%b want %h/%b/%b", got, w8_out_sum, w8_out_cout, w8_out_ovf, e.sum[7:0], e.cout, e.ovf);
          end
        end
      end
      prev_stall = (w8_out_valid === 1'b1) && !w8_out_ready;
      prev_sum   = w8_out_sum;
      if (w8_in_valid && w8_in_ready === 1'b1)
        q.push_back(model(8, {24'h0, w8_in_a}, {24'h0, w8_in_b}, w8_in_cin, w8_in_op));
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain: got %0d pending want 0", q.size());
    end
    $display("random8: %0d results checked, %0d new mismatches", got, n_err - errs_before);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_random8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
